// File: rtl/mmu_sequencer_if.sv
// mmu_sequencer_if: command, stall, MMU-side and result signals of the MMU sequencer
interface mmu_sequencer_if;
    logic        flush_i;
    logic        cmd_valid_i;
    logic [1:0]  cmd_op_i;
    logic [4:0]  row_i;
    logic [4:0]  col_i;
    logic [31:0] data_i;
    logic        cmd_ready_o;
    logic        stall_o;
    logic        mmu_we_a_o;
    logic        mmu_we_b_o;
    logic [4:0]  mmu_row_o;
    logic [4:0]  mmu_col_o;
    logic [31:0] mmu_data_o;
    logic        mmu_start_o;
    logic [31:0] mmu_cout_i;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        done_o;
    logic        range_err_o;

    modport slave (
        input  flush_i, cmd_valid_i, cmd_op_i, row_i, col_i, data_i, mmu_cout_i,
        output cmd_ready_o, stall_o, mmu_we_a_o, mmu_we_b_o, mmu_row_o, mmu_col_o,
               mmu_data_o, mmu_start_o, result_o, result_valid_o, done_o, range_err_o
    );

    modport master (
        output flush_i, cmd_valid_i, cmd_op_i, row_i, col_i, data_i, mmu_cout_i,
        input  cmd_ready_o, stall_o, mmu_we_a_o, mmu_we_b_o, mmu_row_o, mmu_col_o,
               mmu_data_o, mmu_start_o, result_o, result_valid_o, done_o, range_err_o
    );
endinterface

// File: rtl/mmu_sequencer.sv
// mmu_sequencer: command sequencer, compute timer and C readback for a DIM x DIM matrix-multiply unit
module mmu_sequencer #(
    parameter int DIM         = 8,
    parameter int COMPUTE_CYC = 3 * DIM - 2
) (
    input logic            clk_i,
    input logic            rst_i,
    mmu_sequencer_if.slave bus
);
    localparam int         CW    = $clog2(COMPUTE_CYC + 1);
    localparam logic [5:0] DIM_W = 6'(DIM);
    localparam logic [1:0] OP_WR_A  = 2'b00;
    localparam logic [1:0] OP_WR_B  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;

    typedef enum logic [1:0] {IDLE, RD_WAIT, COMPUTE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          rd_err;
    logic          ready;
    logic          accept;
    logic          in_range;

    // Commands are taken in IDLE and DONE; a flushed command is dropped, never accepted
    always_comb begin
        ready    = (state == IDLE) || (state == DONE);
        accept   = bus.cmd_valid_i && ready && !bus.flush_i;
        in_range = ({1'b0, bus.row_i} < DIM_W) && ({1'b0, bus.col_i} < DIM_W);
    end

    assign bus.cmd_ready_o = ready;
    assign bus.stall_o     = (bus.cmd_valid_i && !ready) || (state == COMPUTE);

    // Sequencer FSM; every MMU-side and result output is registered one cycle after accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= IDLE;
            count              <= '0;
            rd_err             <= 1'b0;
            bus.mmu_we_a_o     <= 1'b0;
            bus.mmu_we_b_o     <= 1'b0;
            bus.mmu_row_o      <= '0;
            bus.mmu_col_o      <= '0;
            bus.mmu_data_o     <= '0;
            bus.mmu_start_o    <= 1'b0;
            bus.result_o       <= '0;
            bus.result_valid_o <= 1'b0;
            bus.done_o         <= 1'b0;
            bus.range_err_o    <= 1'b0;
        end else begin
            bus.mmu_we_a_o     <= 1'b0;
            bus.mmu_we_b_o     <= 1'b0;
            bus.mmu_start_o    <= 1'b0;
            bus.result_valid_o <= 1'b0;
            bus.done_o         <= 1'b0;
            bus.range_err_o    <= 1'b0;
            case (state)
                COMPUTE: begin
                    if (count == '0) begin
                        state      <= DONE;
                        bus.done_o <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RD_WAIT: begin
                    state <= IDLE;
                    if (!bus.flush_i) begin
                        bus.result_valid_o <= 1'b1;
                        bus.result_o       <= rd_err ? 32'd0 : bus.mmu_cout_i;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (accept) begin
                        if (bus.cmd_op_i == OP_START) begin
                            state           <= COMPUTE;
                            count           <= CW'(COMPUTE_CYC - 1);
                            bus.mmu_start_o <= 1'b1;
                        end else if (!in_range) begin
                            bus.range_err_o <= 1'b1;
                            rd_err          <= 1'b1;
                            state           <= (bus.cmd_op_i[1]) ? RD_WAIT : IDLE;
                        end else begin
                            bus.mmu_row_o <= bus.row_i;
                            bus.mmu_col_o <= bus.col_i;
                            rd_err        <= 1'b0;
                            if (bus.cmd_op_i[1]) begin
                                state <= RD_WAIT;
                            end else begin
                                bus.mmu_we_a_o <= (bus.cmd_op_i == OP_WR_A);
                                bus.mmu_we_b_o <= (bus.cmd_op_i == OP_WR_B);
                                bus.mmu_data_o <= bus.data_i;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer: timeline reference model plus MMU emulator checking mmu_sequencer every cycle
module tb_mmu_sequencer;
    localparam int DIM = 8;
    localparam int CC  = 3 * DIM - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mmu_sequencer_if bus ();

    mmu_sequencer #(.DIM(DIM), .COMPUTE_CYC(CC)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MMU emulator: buffers written by the strobes, C = A x B formed on the start pulse
    logic [31:0] a_mem[DIM][DIM];
    logic [31:0] b_mem[DIM][DIM];
    logic [31:0] c_mem[DIM][DIM];

    assign bus.mmu_cout_i = c_mem[bus.mmu_row_o[2:0]][bus.mmu_col_o[2:0]];

    always @(posedge clk) begin
        logic [31:0] s;
        if (bus.mmu_we_a_o) a_mem[bus.mmu_row_o[2:0]][bus.mmu_col_o[2:0]] <= bus.mmu_data_o;
        if (bus.mmu_we_b_o) b_mem[bus.mmu_row_o[2:0]][bus.mmu_col_o[2:0]] <= bus.mmu_data_o;
        if (bus.mmu_start_o)
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    s = 0;
                    for (int k = 0; k < DIM; k++) s += a_mem[i][k] * b_mem[k][j];
                    c_mem[i][j] <= s;
                end
    end

    // Reference model: cycle timeline of when the sequencer is free, computing, or owes a result
    int          cyc = 0;
    int          free_at = 0;
    int          comp_lo = 1;
    int          comp_hi = 0;
    int          done_at = -1;
    int          rd_due = -1;
    logic [31:0] rd_val;
    logic [31:0] ma[DIM][DIM];
    logic [31:0] mb[DIM][DIM];
    logic [31:0] mc[DIM][DIM];
    logic        e_we_a, e_we_b, e_start, e_rv, e_done, e_err;
    logic [4:0]  e_row, e_col;
    logic [31:0] e_data, e_result;

    initial begin
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                a_mem[i][j] = 0; b_mem[i][j] = 0; c_mem[i][j] = 0;
                ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0;
            end
    end

    always @(posedge clk) begin
        logic        inr;
        logic [31:0] s;
        if (rst) begin
            {e_we_a, e_we_b, e_start, e_rv, e_done, e_err} = '0;
            e_row = 0; e_col = 0; e_data = 0; e_result = 0;
            free_at = 0; comp_lo = 1; comp_hi = 0; done_at = -1; rd_due = -1;
        end else begin
            {e_we_a, e_we_b, e_start, e_rv, e_done, e_err} = '0;
            if (rd_due == cyc + 1) begin
                if (!bus.flush_i) begin
                    e_rv = 1; e_result = rd_val;
                end
                rd_due = -1;
            end
            if (done_at == cyc + 1) e_done = 1;
            if (bus.cmd_valid_i && cyc >= free_at && !bus.flush_i) begin
                inr = bus.row_i < DIM && bus.col_i < DIM;
                if (bus.cmd_op_i == 2) begin
                    for (int i = 0; i < DIM; i++)
                        for (int j = 0; j < DIM; j++) begin
                            s = 0;
                            for (int k = 0; k < DIM; k++) s += ma[i][k] * mb[k][j];
                            mc[i][j] = s;
                        end
                    e_start = 1;
                    comp_lo = cyc + 1; comp_hi = cyc + CC;
                    free_at = cyc + CC + 1; done_at = free_at;
                end else if (!inr) begin
                    e_err = 1;
                    if (bus.cmd_op_i == 3) begin
                        rd_val = 0; rd_due = cyc + 2; free_at = cyc + 2;
                    end
                end else begin
                    e_row = bus.row_i; e_col = bus.col_i;
                    if (bus.cmd_op_i == 3) begin
                        rd_val = mc[bus.row_i[2:0]][bus.col_i[2:0]];
                        rd_due = cyc + 2; free_at = cyc + 2;
                    end else begin
                        e_data = bus.data_i;
                        if (bus.cmd_op_i == 0) begin
                            e_we_a = 1; ma[bus.row_i[2:0]][bus.col_i[2:0]] = bus.data_i;
                        end else begin
                            e_we_b = 1; mb[bus.row_i[2:0]][bus.col_i[2:0]] = bus.data_i;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // Compare process: every DUT output against the model, mid-cycle
    always @(negedge clk) begin
        logic ready;
        if (!rst) begin
            ready = cyc >= free_at;
            check("cmd_ready", bus.cmd_ready_o, ready);
            check("stall", bus.stall_o, (bus.cmd_valid_i && !ready) || (cyc >= comp_lo && cyc <= comp_hi));
            check("we_a", bus.mmu_we_a_o, e_we_a);
            check("we_b", bus.mmu_we_b_o, e_we_b);
            check("start", bus.mmu_start_o, e_start);
            check("mmu_row", bus.mmu_row_o, e_row);
            check("mmu_col", bus.mmu_col_o, e_col);
            check("mmu_data", bus.mmu_data_o, e_data);
            check("result_valid", bus.result_valid_o, e_rv);
            check("result", bus.result_o, e_result);
            check("done", bus.done_o, e_done);
            check("range_err", bus.range_err_o, e_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] r, input logic [4:0] c, input logic [31:0] d);
        int   n = 0;
        logic acc;
        bus.cmd_valid_i = 1; bus.cmd_op_i = op; bus.row_i = r; bus.col_i = c; bus.data_i = d;
        do begin
            acc = bus.cmd_ready_o;
            step();
            n++;
        end while (!acc && n < 100);
        check("issue_accept", acc, 1);
        bus.cmd_valid_i = 0;
    endtask

    initial begin
        int          n;
        int          we_seen;
        logic [4:0]  r0;
        bus.flush_i = 0; bus.cmd_valid_i = 0; bus.cmd_op_i = 0;
        bus.row_i = 0; bus.col_i = 0; bus.data_i = 0;
        repeat (3) step();
        check("rst_result", bus.result_o, 0);
        check("rst_we_a", bus.mmu_we_a_o, 0);
        rst = 0;
        check("ready_after_rst", bus.cmd_ready_o, 1);

        issue(2'b00, 5'd2, 5'd3, 32'hDEADBEEF);
        check("wa_we", bus.mmu_we_a_o, 1);
        check("wa_row", bus.mmu_row_o, 2);
        check("wa_col", bus.mmu_col_o, 3);
        check("wa_data", bus.mmu_data_o, 32'hDEADBEEF);
        step();
        check("wa_once", bus.mmu_we_a_o, 0);

        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                issue(2'b00, 5'(i), 5'(j), (i == j) ? 32'd1 : 32'd0);
                issue(2'b01, 5'(i), 5'(j), 32'(i * DIM + j + 1));
            end
        issue(2'b10, 0, 0, 0);
        check("start_pulse", bus.mmu_start_o, 1);
        n = 0;
        while (bus.stall_o && n < 100) begin
            n++;
            step();
        end
        check("stall_cycles", n, 22);
        check("done_pulse", bus.done_o, 1);
        issue(2'b11, 5'd1, 5'd4, 0);
        check("rd_not_yet", bus.result_valid_o, 0);
        step();
        check("rd_valid", bus.result_valid_o, 1);
        check("rd_value", bus.result_o, 13);

        issue(2'b10, 0, 0, 0);
        bus.cmd_valid_i = 1; bus.cmd_op_i = 2'b00; bus.row_i = 0; bus.col_i = 0; bus.data_i = 32'h55;
        n = 0; we_seen = 0;
        while (!bus.cmd_ready_o && n < 100) begin
            n++;
            we_seen += int'(bus.mmu_we_a_o) + int'(bus.mmu_we_b_o);
            step();
        end
        check("busy_cycles", n, 22);
        check("no_we_in_compute", we_seen, 0);
        check("accept_in_done", bus.done_o, 1);
        step();
        bus.cmd_valid_i = 0;
        check("we_after_done", bus.mmu_we_a_o, 1);

        r0 = bus.mmu_row_o;
        issue(2'b11, 5'd8, 5'd0, 0);
        check("rng_err", bus.range_err_o, 1);
        check("rng_row_held", bus.mmu_row_o, r0);
        step();
        check("rng_valid", bus.result_valid_o, 1);
        check("rng_result", bus.result_o, 0);

        issue(2'b11, 5'd2, 5'd2, 0);
        bus.flush_i = 1;
        step();
        bus.flush_i = 0;
        check("flush_rd", bus.result_valid_o, 0);

        issue(2'b10, 0, 0, 0);
        for (int k = 0; k < CC; k++) begin
            bus.flush_i = k < 10;
            step();
        end
        bus.flush_i = 0;
        check("flush_compute_done", bus.done_o, 1);

        for (int t = 0; t < 2000; t++) begin
            int r;
            r = $urandom_range(0, 15);
            bus.cmd_valid_i = $urandom_range(0, 9) < 7;
            bus.cmd_op_i = r < 6 ? 2'b00 : r < 12 ? 2'b01 : r < 13 ? 2'b10 : 2'b11;
            bus.row_i = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
            bus.col_i = 5'($urandom_range(0, 8));
            bus.data_i = $urandom;
            bus.flush_i = $urandom_range(0, 9) == 0;
            step();
        end
        bus.cmd_valid_i = 0; bus.flush_i = 0;
        repeat (30) step();

        issue(2'b10, 0, 0, 0);
        repeat (5) step();
        #2;
        rst = 1;
        #1;
        check("arst_stall", bus.stall_o, 0);
        check("arst_start", bus.mmu_start_o, 0);
        check("arst_done", bus.done_o, 0);
        check("arst_row", bus.mmu_row_o, 0);
        check("arst_result", bus.result_o, 0);
        check("arst_rv", bus.result_valid_o, 0);
        step();
        rst = 0;
        check("arst_ready", bus.cmd_ready_o, 1);
        issue(2'b11, 5'd3, 5'd3, 0);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
